// File: rtl/ysig_pkg.sv
// Shared types and defaults for the ysig output-signature compactor.
package ysig_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [63:0] DEFAULT_POLY = 64'h0000_0000_04C1_1DB7;
    localparam logic [63:0] DEFAULT_SEED = 64'h0000_0000_FFFF_FFFF;

    // Number of SIG_WIDTH slices needed to cover a y vector (ceiling division).
    function automatic int fold_slices(input int y_w, input int s_w);
        return (y_w + s_w - 1) / s_w;
    endfunction

endpackage

// File: rtl/ysig_misr.sv
// Per-channel fold (zero-pad, XOR all SIG_WIDTH slices) feeding a MISR register.
module ysig_misr
    import ysig_pkg::*;
#(
    parameter int                   Y_WIDTH   = 242,
    parameter int                   SIG_WIDTH = 32,
    parameter logic [SIG_WIDTH-1:0] POLY      = DEFAULT_POLY[SIG_WIDTH-1:0],
    parameter logic [SIG_WIDTH-1:0] SEED      = DEFAULT_SEED[SIG_WIDTH-1:0]
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 en,
    input  logic [Y_WIDTH-1:0]   y,
    output logic [SIG_WIDTH-1:0] sig
);

    localparam int N_SLICES = fold_slices(Y_WIDTH, SIG_WIDTH);

    logic [N_SLICES*SIG_WIDTH-1:0] y_pad;
    logic [SIG_WIDTH-1:0]          fold;
    logic [SIG_WIDTH-1:0]          sig_q;
    logic [SIG_WIDTH-1:0]          sig_d;

    always_comb begin
        y_pad              = '0;
        y_pad[Y_WIDTH-1:0] = y;
        fold               = '0;
        for (int s = 0; s < N_SLICES; s++) begin
            fold = fold ^ y_pad[s*SIG_WIDTH +: SIG_WIDTH];
        end
    end

    // load (run start) takes priority over a sample in the same cycle
    always_comb begin
        sig_d = sig_q;
        if (load) begin
            sig_d = SEED;
        end else if (en) begin
            sig_d = {sig_q[SIG_WIDTH-2:0], 1'b0}
                  ^ (sig_q[SIG_WIDTH-1] ? POLY : '0)
                  ^ fold;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= SEED;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/ysig_compactor.sv
// Multi-channel y-vector signature compactor with raw mismatch counting.
// Optional first-mismatch capture is built when YSIG_FIRST_DIFF_EN is defined.
//
// state | meaning
// IDLE  | after reset, waiting for start
// RUN   | consuming valid samples until WINDOW have been taken
// DONE  | window complete, outputs frozen until the next start
module ysig_compactor
    import ysig_pkg::*;
#(
    parameter int          Y_WIDTH   = 242,
    parameter int          CHANNELS  = 2,
    parameter int          SIG_WIDTH = 32,
    parameter logic [63:0] POLY      = DEFAULT_POLY,
    parameter logic [63:0] SEED      = DEFAULT_SEED,
    parameter int          WINDOW    = 1024,
    parameter int          CNT_WIDTH = 21
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          y_valid,
    input  logic [CHANNELS*Y_WIDTH-1:0]   y_bus,
    output logic                          busy,
    output logic                          done,
    output logic                          mismatch,
    output logic [CNT_WIDTH-1:0]          mismatch_count,
    output logic [CNT_WIDTH-1:0]          sample_count,
    output logic [CHANNELS*SIG_WIDTH-1:0] sig_bus,
    output logic [CNT_WIDTH-1:0]          first_diff_cycle,
    output logic [2:0]                    first_diff_chan
);

    localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(WINDOW - 1);

    state_e                state_q;
    logic [CNT_WIDTH-1:0]  sample_cnt_q;
    logic [CNT_WIDTH-1:0]  mism_cnt_q;
    logic                  mismatch_q;
    logic                  start_go;
    logic                  accept;
    logic                  any_mism;
    logic [CHANNELS-1:0]   chan_diff;

    assign start_go = start && (state_q != RUN);
    assign accept   = y_valid && (state_q == RUN);

    // Raw comparison against the golden channel 0; bit 0 stays clear.
    always_comb begin
        chan_diff = '0;
        for (int k = 1; k < CHANNELS; k++) begin
            chan_diff[k] = (y_bus[k*Y_WIDTH +: Y_WIDTH] != y_bus[0 +: Y_WIDTH]);
        end
    end
    assign any_mism = |chan_diff;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        ysig_misr #(
            .Y_WIDTH  (Y_WIDTH),
            .SIG_WIDTH(SIG_WIDTH),
            .POLY     (POLY[SIG_WIDTH-1:0]),
            .SEED     (SEED[SIG_WIDTH-1:0])
        ) u_misr (
            .clk  (clk),
            .rst_n(rst_n),
            .load (start_go),
            .en   (accept),
            .y    (y_bus[g*Y_WIDTH +: Y_WIDTH]),
            .sig  (sig_bus[g*SIG_WIDTH +: SIG_WIDTH])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sample_cnt_q <= '0;
            mism_cnt_q   <= '0;
            mismatch_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q      <= RUN;
                        sample_cnt_q <= '0;
                        mism_cnt_q   <= '0;
                        mismatch_q   <= 1'b0;
                    end
                end
                RUN: begin
                    if (y_valid) begin
                        sample_cnt_q <= sample_cnt_q + CNT_WIDTH'(1);
                        if (any_mism) begin
                            mismatch_q <= 1'b1;
                            if (mism_cnt_q != '1) begin
                                mism_cnt_q <= mism_cnt_q + CNT_WIDTH'(1);
                            end
                        end
                        if (sample_cnt_q == LAST_IDX) begin
                            state_q <= DONE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy           = (state_q == RUN);
    assign done           = (state_q == DONE);
    assign mismatch       = mismatch_q;
    assign mismatch_count = mism_cnt_q;
    assign sample_count   = sample_cnt_q;

`ifdef YSIG_FIRST_DIFF_EN
    logic [CNT_WIDTH-1:0] fd_cycle_q;
    logic [2:0]           fd_chan_q;
    logic [2:0]           low_chan;

    always_comb begin
        low_chan = '0;
        for (int k = CHANNELS - 1; k >= 1; k--) begin
            if (chan_diff[k]) low_chan = 3'(k);
        end
    end

    // Only the first mismatching sample of a run is captured (mismatch_q still clear).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fd_cycle_q <= '0;
            fd_chan_q  <= '0;
        end else if (start_go) begin
            fd_cycle_q <= '0;
            fd_chan_q  <= '0;
        end else if (accept && any_mism && !mismatch_q) begin
            fd_cycle_q <= sample_cnt_q;
            fd_chan_q  <= low_chan;
        end
    end

    assign first_diff_cycle = fd_cycle_q;
    assign first_diff_chan  = fd_chan_q;
`else
    assign first_diff_cycle = '0;
    assign first_diff_chan  = '0;
`endif

endmodule
